// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one add-3 + shift step per clock,
// all digits adjusted in parallel. Optional signed mode converts the magnitude and reports the sign.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd_out,
  output logic                  o_sign_out,
  output logic                  o_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;

  logic [BIN_W-1:0]   r_mag;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf_sticky;
  logic               r_sign;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_sign_out;
  logic               r_ovf;

  logic               w_neg;
  logic [BIN_W-1:0]   w_mag_load;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic [BIN_W-1:0]   w_mag_shift;
  logic               w_carry;

  // Negative operands are converted as their magnitude; the most-negative value maps to 2^(BIN_W-1).
  assign w_neg      = (SIGNED != 0) && i_bin_in[BIN_W-1];
  assign w_mag_load = w_neg ? (~i_bin_in + BIN_W'(1)) : i_bin_in;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? (r_bcd[4*gi +: 4] + 4'd3)
                                                          : r_bcd[4*gi +: 4];
    end
  endgenerate

  assign w_bcd_shift = {w_adj[BCD_W-2:0], r_mag[BIN_W-1]};
  assign w_mag_shift = {r_mag[BIN_W-2:0], 1'b0};
  assign w_carry     = w_adj[BCD_W-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mag        <= '0;
      r_bcd        <= '0;
      r_ovf_sticky <= 1'b0;
      r_sign       <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_bcd_out    <= '0;
      r_sign_out   <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mag        <= w_mag_load;
        r_sign       <= w_neg;
        r_bcd        <= '0;
        r_ovf_sticky <= 1'b0;
        r_cnt        <= '0;
        r_busy       <= 1'b1;
      end else if (r_state == S_CONV) begin
        r_mag        <= w_mag_shift;
        r_bcd        <= w_bcd_shift;
        r_ovf_sticky <= r_ovf_sticky | w_carry;
        r_cnt        <= r_cnt + CNT_W'(1);
        // Final iteration publishes the post-shift scratch directly.
        if (w_last) begin
          r_bcd_out  <= w_bcd_shift;
          r_sign_out <= r_sign;
          r_ovf      <= r_ovf_sticky | w_carry;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_bcd_out  = r_bcd_out;
  assign o_sign_out = r_sign_out;
  assign o_ovf      = r_ovf;

endmodule
